// File: rtl/debounce_bank.sv
// N-channel button debouncer with a 2-flop synchronizer, rise/fall strobes and
// keyboard-style auto-repeat on each channel.
module debounce_bank #(
   parameter int N     = 4,
   parameter int DELAY = 270000,
   parameter int HOLD  = 13500000,
   parameter int RATE  = 2700000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] noisy,
   output logic [N-1:0] clean,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic [N-1:0] rep,
   output logic         changed
);

   // A zero DELAY still needs a one-bit counter to compare against.
   localparam int DW  = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
   localparam int HW  = $clog2(HOLD + 1);
   localparam int RW  = $clog2(RATE + 1);
   localparam int RCW = (HW > RW) ? HW : RW;

   localparam logic [DW-1:0]  DELAY_C  = DW'(DELAY);
   localparam logic [RCW-1:0] HOLD_END = RCW'(HOLD - 1);
   localparam logic [RCW-1:0] RATE_END = RCW'(RATE - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      REPEAT
   } rep_state_t;

   logic [N-1:0] rise_d;
   logic [N-1:0] fall_d;

   for (genvar i = 0; i < N; i++) begin : g_chan
      logic           s1;
      logic           s2;
      logic           cand;
      logic [DW-1:0]  cnt;
      logic           clean_q;
      logic           rise_q;
      logic           fall_q;
      logic           rep_q;
      logic           rep_d;
      logic           settled;
      logic [RCW-1:0] rcnt;
      logic [RCW-1:0] rcnt_d;
      rep_state_t     state;
      rep_state_t     state_d;

      // Strobes use the exact condition under which clean takes the candidate.
      assign settled   = (s2 == cand) && (cnt == DELAY_C);
      assign rise_d[i] = settled && cand && !clean_q;
      assign fall_d[i] = settled && !cand && clean_q;

      always_ff @(posedge clock) begin
         if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cand    <= 1'b0;
            cnt     <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            s1 <= noisy[i];
            s2 <= s1;
            if (s2 != cand) begin
               cand <= s2;
               cnt  <= '0;
            end else if (cnt == DELAY_C) begin
               clean_q <= cand;
            end else begin
               cnt <= cnt + 1'b1;
            end
            rise_q <= rise_d[i];
            fall_q <= fall_d[i];
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            state <= IDLE;
            rcnt  <= '0;
            rep_q <= 1'b0;
         end else begin
            state <= state_d;
            rcnt  <= rcnt_d;
            rep_q <= rep_d;
         end
      end

      // A release always wins over a repeat expiry landing on the same edge.
      always_comb begin
         state_d = state;
         rcnt_d  = rcnt;
         rep_d   = 1'b0;
         unique case (state)
            IDLE: begin
               if (rise_d[i]) begin
                  state_d = PRESS;
                  rcnt_d  = '0;
                  rep_d   = 1'b1;
               end
            end
            PRESS: begin
               if (fall_d[i]) begin
                  state_d = IDLE;
                  rcnt_d  = '0;
               end else if (rcnt == HOLD_END) begin
                  state_d = REPEAT;
                  rcnt_d  = '0;
                  rep_d   = 1'b1;
               end else begin
                  rcnt_d = rcnt + 1'b1;
               end
            end
            REPEAT: begin
               if (fall_d[i]) begin
                  state_d = IDLE;
                  rcnt_d  = '0;
               end else if (rcnt == RATE_END) begin
                  rcnt_d = '0;
                  rep_d  = 1'b1;
               end else begin
                  rcnt_d = rcnt + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               rcnt_d  = '0;
            end
         endcase
      end

      assign clean[i] = clean_q;
      assign rise[i]  = rise_q;
      assign fall[i]  = fall_q;
      assign rep[i]   = rep_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         changed <= 1'b0;
      end else begin
         changed <= |(rise_d | fall_d);
      end
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: a window-based reference model checked every cycle,
// plus directed scenarios with hand-computed event timings.
module tb_debounce_bank;

   localparam int N     = 4;
   localparam int DELAY = 8;
   localparam int HOLD  = 20;
   localparam int RATE  = 5;
   localparam int W     = DELAY + 2;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] noisy;
   logic [N-1:0] clean;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] rep;
   logic         changed;

   int checks   = 0;
   int failures = 0;

   debounce_bank #(
      .N     (N),
      .DELAY (DELAY),
      .HOLD  (HOLD),
      .RATE  (RATE)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .noisy   (noisy),
      .clean   (clean),
      .rise    (rise),
      .fall    (fall),
      .rep     (rep),
      .changed (changed)
   );

   always #5 clock = ~clock;

   // Reference model: clean follows a level once the synchronized input has held
   // that level for the last DELAY+2 edges; repeats are timed from the rise edge.
   typedef struct packed {
      logic [W-1:0] h;
      logic         clean;
      logic         rise;
      logic         fall;
      logic         rep;
      logic         pressed;
      logic [31:0]  trise;
   } chan_t;

   chan_t        cur [N];
   chan_t        nxt [N];
   logic [N-1:0] m_s1;
   logic [N-1:0] m_s2;
   logic         m_changed;
   logic         any_evt;
   logic [N-1:0] exp_clean;
   logic [N-1:0] exp_rise;
   logic [N-1:0] exp_fall;
   logic [N-1:0] exp_rep;
   int           cyc         = 0;
   logic         model_valid = 1'b0;
   int           rep_ticks[$];

   function automatic chan_t step(input chan_t c, input logic s2, input int now);
      chan_t n;
      int    d;
      n      = c;
      n.h    = {c.h[W-2:0], s2};
      n.rise = (&n.h) && !c.clean;
      n.fall = (~|n.h) && c.clean;
      n.rep  = 1'b0;
      if (n.rise) begin
         n.clean   = 1'b1;
         n.pressed = 1'b1;
         n.trise   = 32'(now);
         n.rep     = 1'b1;
      end else if (n.fall) begin
         n.clean   = 1'b0;
         n.pressed = 1'b0;
      end else if (c.pressed) begin
         d     = now - int'(c.trise);
         n.rep = (d >= HOLD) && (((d - HOLD) % RATE) == 0);
      end
      return n;
   endfunction

   always_comb begin
      any_evt   = 1'b0;
      exp_clean = '0;
      exp_rise  = '0;
      exp_fall  = '0;
      exp_rep   = '0;
      for (int i = 0; i < N; i++) begin
         nxt[i]       = step(cur[i], m_s2[i], cyc);
         any_evt      = any_evt | nxt[i].rise | nxt[i].fall;
         exp_clean[i] = cur[i].clean;
         exp_rise[i]  = cur[i].rise;
         exp_fall[i]  = cur[i].fall;
         exp_rep[i]   = cur[i].rep;
      end
   end

   always @(posedge clock) begin
      cyc         <= cyc + 1;
      model_valid <= 1'b1;
      if (reset) begin
         m_s1      <= '0;
         m_s2      <= '0;
         m_changed <= 1'b0;
         for (int i = 0; i < N; i++) cur[i] <= '0;
      end else begin
         m_s1      <= noisy;
         m_s2      <= m_s1;
         m_changed <= any_evt;
         for (int i = 0; i < N; i++) cur[i] <= nxt[i];
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Every cycle the bench advances, the DUT is compared against the model.
   task automatic tick();
      @(negedge clock);
      if (model_valid) begin
         check_output("model_clean", 32'(clean), 32'(exp_clean));
         check_output("model_rise", 32'(rise), 32'(exp_rise));
         check_output("model_fall", 32'(fall), 32'(exp_fall));
         check_output("model_rep", 32'(rep), 32'(exp_rep));
         check_output("model_changed", 32'(changed), 32'(m_changed));
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic apply_stimulus(input logic [N-1:0] v);
      noisy = v;
   endtask

   task automatic watch(input int n, input int ch, output int n_rise, output int n_fall,
                        output int first_rise, output int first_fall);
      n_rise     = 0;
      n_fall     = 0;
      first_rise = -1;
      first_fall = -1;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (rise[ch]) begin
            n_rise++;
            if (first_rise < 0) first_rise = k;
         end
         if (fall[ch]) begin
            n_fall++;
            if (first_fall < 0) first_fall = k;
         end
      end
   endtask

   task automatic record_rep(input int n, input int ch);
      rep_ticks.delete();
      for (int k = 1; k <= n; k++) begin
         tick();
         if (rep[ch]) rep_ticks.push_back(k);
      end
   endtask

   initial begin
      int           nr;
      int           nf;
      int           fr;
      int           ff;
      int           tot_r;
      int           tot_f;
      logic [N-1:0] v;

      // Reset held with ch0 already pressed, then released.
      reset = 1'b1;
      apply_stimulus(4'b0001);
      wait_ticks(3);
      check_output("t1_reset_clean", 32'(clean), 32'h0);
      check_output("t1_reset_rep", 32'(rep), 32'h0);
      check_output("t1_reset_changed", 32'(changed), 32'h0);
      reset = 1'b0;
      wait_ticks(11);
      check_output("t1_before_clean", 32'(clean), 32'h0);
      wait_ticks(1);
      check_output("t1_clean", 32'(clean), 32'b0001);
      check_output("t1_rise", 32'(rise), 32'b0001);
      check_output("t1_rep", 32'(rep), 32'b0001);
      check_output("t1_changed", 32'(changed), 32'h1);
      wait_ticks(1);
      check_output("t1_rise_one_cycle", 32'(rise), 32'h0);
      check_output("t1_changed_one_cycle", 32'(changed), 32'h0);

      // ch1: settle high, then an 8-cycle dropout must be ignored.
      apply_stimulus(4'b0011);
      wait_ticks(12);
      check_output("t2_rise1", 32'(rise[1]), 32'h1);
      wait_ticks(5);
      apply_stimulus(4'b0001);
      watch(8, 1, nr, nf, fr, ff);
      tot_f = nf;
      apply_stimulus(4'b0011);
      watch(20, 1, nr, nf, fr, ff);
      tot_f += nf;
      check_output("t2_short_drop_no_fall", 32'(tot_f), 32'h0);
      check_output("t2_short_drop_clean", 32'(clean[1]), 32'h1);
      apply_stimulus(4'b0001);
      watch(15, 1, nr, nf, fr, ff);
      check_output("t2_long_drop_falls", 32'(nf), 32'h1);
      check_output("t2_fall_latency", 32'(ff), 32'd12);

      // ch2: six 3-cycle bounce phases, then stable high.
      tot_r = 0;
      tot_f = 0;
      for (int p = 0; p < 6; p++) begin
         v    = 4'b0001;
         v[2] = (p % 2 == 0);
         apply_stimulus(v);
         watch(3, 2, nr, nf, fr, ff);
         tot_r += nr;
         tot_f += nf;
      end
      apply_stimulus(4'b0101);
      watch(15, 2, nr, nf, fr, ff);
      tot_r += nr;
      tot_f += nf;
      check_output("t3_single_rise", 32'(tot_r), 32'h1);
      check_output("t3_no_fall", 32'(tot_f), 32'h0);
      check_output("t3_rise_latency", 32'(fr), 32'd12);

      // ch3: auto-repeat timeline, release on a repeat expiry, then re-press.
      apply_stimulus(4'b1101);
      record_rep(50, 3);
      check_output("t4_rep_count", 32'(rep_ticks.size()), 32'd5);
      if (rep_ticks.size() == 5) begin
         check_output("t4_rep0", 32'(rep_ticks[0]), 32'd12);
         check_output("t4_rep1", 32'(rep_ticks[1]), 32'd32);
         check_output("t4_rep2", 32'(rep_ticks[2]), 32'd37);
         check_output("t4_rep3", 32'(rep_ticks[3]), 32'd42);
         check_output("t4_rep4", 32'(rep_ticks[4]), 32'd47);
      end
      apply_stimulus(4'b0101);
      record_rep(11, 3);
      check_output("t4_release_reps", 32'(rep_ticks.size()), 32'd2);
      wait_ticks(1);
      check_output("t4_fall3", 32'(fall[3]), 32'h1);
      check_output("t4_fall_beats_repeat", 32'(rep[3]), 32'h0);
      wait_ticks(3);
      apply_stimulus(4'b1101);
      record_rep(25, 3);
      check_output("t4_repress_count", 32'(rep_ticks.size()), 32'd1);
      if (rep_ticks.size() == 1) check_output("t4_repress_tick", 32'(rep_ticks[0]), 32'd12);

      // ch0 rises and ch1 falls on the same edge.
      apply_stimulus(4'b1110);
      wait_ticks(15);
      apply_stimulus(4'b1101);
      wait_ticks(11);
      check_output("t5_changed_before", 32'(changed), 32'h0);
      wait_ticks(1);
      check_output("t5_rise", 32'(rise), 32'b0001);
      check_output("t5_fall", 32'(fall), 32'b0010);
      check_output("t5_changed", 32'(changed), 32'h1);
      wait_ticks(1);
      check_output("t5_changed_after", 32'(changed), 32'h0);

      // Reset mid-count on ch1 and mid-repeat on ch0/ch3.
      wait_ticks(30);
      apply_stimulus(4'b1111);
      wait_ticks(8);
      reset = 1'b1;
      wait_ticks(1);
      check_output("t6_clean", 32'(clean), 32'h0);
      check_output("t6_rise", 32'(rise), 32'h0);
      check_output("t6_fall", 32'(fall), 32'h0);
      check_output("t6_rep", 32'(rep), 32'h0);
      check_output("t6_changed", 32'(changed), 32'h0);
      wait_ticks(1);
      reset = 1'b0;
      wait_ticks(11);
      check_output("t6_clean_before", 32'(clean), 32'h0);
      wait_ticks(1);
      check_output("t6_clean_after", 32'(clean), 32'b1111);
      check_output("t6_rise_after", 32'(rise), 32'b1111);
      check_output("t6_rep_after", 32'(rep), 32'b1111);
      wait_ticks(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
